// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, exception codes, SR/Cause field
// positions and the exception-return address helper.
package cp0_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned EXC_W   = 5;
    localparam int unsigned HWINT_W = 6;
    localparam int unsigned EPC_W   = XLEN - 2;

    // CP0 register numbers
    localparam logic [ADDR_W-1:0] CP0_SR    = 5'd12;
    localparam logic [ADDR_W-1:0] CP0_CAUSE = 5'd13;
    localparam logic [ADDR_W-1:0] CP0_EPC   = 5'd14;
    localparam logic [ADDR_W-1:0] CP0_PRID  = 5'd15;

    // ExcCode values
    localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
    localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
    localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

    // SR field positions
    localparam int unsigned SR_IE    = 0;
    localparam int unsigned SR_EXL   = 1;
    localparam int unsigned SR_IM_LO = 10;
    localparam int unsigned SR_IM_HI = 15;

    // Cause field positions
    localparam int unsigned CAUSE_EXC_LO = 2;
    localparam int unsigned CAUSE_EXC_HI = 6;
    localparam int unsigned CAUSE_IP_LO  = 10;
    localparam int unsigned CAUSE_IP_HI  = 15;
    localparam int unsigned CAUSE_BD     = 31;

    // Word address of the restart point: a delay-slot instruction restarts at its branch.
    // (PC-4)[31:2] equals PC[31:2]-1 with the same 32-bit wrap.
    function automatic logic [EPC_W-1:0] epc_target(input logic [EPC_W-1:0] pc_word,
                                                    input logic bd);
        return bd ? (pc_word - EPC_W'(1)) : pc_word;
    endfunction

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// M-stage to CP0 interface.
//  master: pipeline side, drives addresses, write data, PC/BD, exception code,
//          interrupt lines and eret; receives IntReq, EPC and DOut.
//  slave : CP0 side.
interface cp0_exc_ctrl_if;
    import cp0_pkg::*;

    logic [ADDR_W-1:0]  A1;
    logic [ADDR_W-1:0]  A2;
    logic [XLEN-1:0]    DIn;
    logic               We;
    logic [XLEN-1:0]    PC_M;
    logic               BD_M;
    logic [EXC_W-1:0]   ExcCodeM;
    logic [HWINT_W-1:0] HWInt;
    logic               EXLClr;
    logic               IntReq;
    logic [XLEN-1:0]    EPC;
    logic [XLEN-1:0]    DOut;

    modport master (
        output A1, A2, DIn, We, PC_M, BD_M, ExcCodeM, HWInt, EXLClr,
        input  IntReq, EPC, DOut
    );

    modport slave (
        input  A1, A2, DIn, We, PC_M, BD_M, ExcCodeM, HWInt, EXLClr,
        output IntReq, EPC, DOut
    );

endinterface

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 and exception/interrupt controller for the M stage.
// Holds SR/Cause/EPC/PRId, raises IntReq (combinational, same-cycle flush),
// services mfc0/mtc0 and eret.
// Ports:
//  clk    : clock, all state updates on posedge
//  reset  : asynchronous active-low reset
//  bus    : cp0_exc_ctrl_if.slave (A1/A2/DIn/We/PC_M/BD_M/ExcCodeM/HWInt/EXLClr in,
//           IntReq/EPC/DOut out)
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [XLEN-1:0] PRID_VALUE = 32'h2020_1215,
    parameter logic [XLEN-1:0] EPC_RESET  = 32'h0000_3000
) (
    input  logic               clk,
    input  logic               reset,
    cp0_exc_ctrl_if.slave      bus
);

    logic [HWINT_W-1:0] sr_im;
    logic               sr_exl;
    logic               sr_ie;
    logic               cause_bd;
    logic [HWINT_W-1:0] cause_ip;
    logic [EXC_W-1:0]   cause_exc;
    logic [EPC_W-1:0]   epc_q;

    logic               int_pend;
    logic               exc_pend;
    logic               int_req;
    logic               wr_sr;
    logic               wr_epc;
    logic [XLEN-1:0]    sr_word;
    logic [XLEN-1:0]    cause_word;
    logic               unused_pc_lsb;

    // Request generation; EXL blocks nesting of both interrupts and exceptions
    assign int_pend = (|(bus.HWInt & sr_im)) & sr_ie & ~sr_exl;
    assign exc_pend = (bus.ExcCodeM != EXC_INT) & ~sr_exl;
    assign int_req  = reset & (int_pend | exc_pend);
    assign bus.IntReq = int_req;

    assign wr_sr  = bus.We & ~int_req & (bus.A2 == CP0_SR);
    assign wr_epc = bus.We & ~int_req & (bus.A2 == CP0_EPC);

    assign unused_pc_lsb = ^bus.PC_M[1:0];

    // Architectural state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc_q     <= EPC_RESET[XLEN-1:2];
        end else begin
            cause_ip <= bus.HWInt;
            if (int_req) begin
                sr_exl    <= 1'b1;
                cause_exc <= int_pend ? EXC_INT : bus.ExcCodeM;
                cause_bd  <= bus.BD_M;
                epc_q     <= epc_target(bus.PC_M[XLEN-1:2], bus.BD_M);
            end else begin
                if (wr_sr) begin
                    sr_im  <= bus.DIn[SR_IM_HI:SR_IM_LO];
                    sr_ie  <= bus.DIn[SR_IE];
                    sr_exl <= bus.DIn[SR_EXL];
                end
                if (wr_epc) begin
                    epc_q <= bus.DIn[XLEN-1:2];
                end
                // eret wins over a same-cycle mtc0 to SR for the EXL bit
                if (bus.EXLClr) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

    // Masked register views
    always_comb begin
        sr_word = '0;
        sr_word[SR_IM_HI:SR_IM_LO] = sr_im;
        sr_word[SR_EXL]            = sr_exl;
        sr_word[SR_IE]             = sr_ie;

        cause_word = '0;
        cause_word[CAUSE_BD]                  = cause_bd;
        cause_word[CAUSE_IP_HI:CAUSE_IP_LO]   = cause_ip;
        cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc;
    end

    // mfc0 read mux, pre-edge values only
    always_comb begin
        bus.DOut = '0;
        case (bus.A1)
            CP0_SR:    bus.DOut = sr_word;
            CP0_CAUSE: bus.DOut = cause_word;
            CP0_EPC:   bus.DOut = {epc_q, 2'b00};
            CP0_PRID:  bus.DOut = PRID_VALUE;
            default:   bus.DOut = '0;
        endcase
    end

    assign bus.EPC = {epc_q, 2'b00};

endmodule
